shift_sequencer: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_step_sel.sv | 39 +++
 rtl/shift_sequencer.sv | 93 +++++++++
 tb/tb_shift_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: op codes, ALU fixed-shift controls, FSM states.
// Pure declarations: no logic, no latency, no flow control.
package shift_seq_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [5:0] ALU_CTRL_IDLE = 6'h00;

  localparam logic [5:0] ALU_SLL1 = 6'h0A;
  localparam logic [5:0] ALU_SLL2 = 6'h0B;
  localparam logic [5:0] ALU_SLL8 = 6'h0C;
  localparam logic [5:0] ALU_SRL1 = 6'h0D;
  localparam logic [5:0] ALU_SRL2 = 6'h0E;
  localparam logic [5:0] ALU_SRL8 = 6'h0F;
  localparam logic [5:0] ALU_SRA1 = 6'h10;
  localparam logic [5:0] ALU_SRA2 = 6'h11;
  localparam logic [5:0] ALU_SRA8 = 6'h12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step_sel.sv
// Picks the largest fixed ALU shift that fits the remaining amount; combinational, no backpressure.
// 8-bit steps exist only when SHIFT_SEQ_STEP8_EN is defined; otherwise steps are 2 or 1.
module shift_step_sel
  import shift_seq_pkg::*;
(
  input  logic [4:0] rem,
  input  logic [1:0] op_q,
  output logic [3:0] step,
  output logic [5:0] alu_ctrl
);

  // size_sel: 0 -> 1-bit, 1 -> 2-bit, 2 -> 8-bit shift
  logic [1:0] size_sel;

  always_comb begin
    step     = 4'd1;
    size_sel = 2'd0;
`ifdef SHIFT_SEQ_STEP8_EN
    if (rem >= 5'd8) begin
      step     = 4'd8;
      size_sel = 2'd2;
    end else
`endif
    if (rem >= 5'd2) begin
      step     = 4'd2;
      size_sel = 2'd1;
    end
  end

  always_comb begin
    alu_ctrl = ALU_CTRL_IDLE;
    case (op_q)
      OP_SRL:  alu_ctrl = (size_sel == 2'd2) ? ALU_SRL8 : (size_sel == 2'd1) ? ALU_SRL2 : ALU_SRL1;
      OP_SRA:  alu_ctrl = (size_sel == 2'd2) ? ALU_SRA8 : (size_sel == 2'd1) ? ALU_SRA2 : ALU_SRA1;
      default: alu_ctrl = (size_sel == 2'd2) ? ALU_SLL8 : (size_sel == 2'd1) ? ALU_SLL2 : ALU_SLL1;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Variable shift (0-31) built from fixed ALU shifts; done after N+1 cycles, N = steps (SHIFT_SEQ_STEP8_EN widens steps).
// No backpressure: start is taken only in IDLE, otherwise dropped.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r
);

  state_t      state, state_d;
  logic [31:0] acc;
  logic [4:0]  rem;
  logic [1:0]  op_q;
  logic [3:0]  step;
  logic [5:0]  step_ctrl;
  logic [4:0]  rem_next;

  shift_step_sel u_step_sel (
    .rem      (rem),
    .op_q     (op_q),
    .step     (step),
    .alu_ctrl (step_ctrl)
  );

  assign rem_next = rem - {1'b0, step};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    busy     = 1'b1;
    done     = 1'b0;
    alu_ctrl = ALU_CTRL_IDLE;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (shamt == 5'd0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_ctrl = step_ctrl;
        if (rem_next == 5'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // result is written on the same edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      rem    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          acc  <= value;
          rem  <= shamt;
          op_q <= op;
          if (shamt == 5'd0) result <= value;
        end
        ST_SHIFT: begin
          acc <= alu_r;
          rem <= rem_next;
          if (rem_next == 5'd0) result <= alu_r;
        end
        default: ;
      endcase
    end
  end

  assign alu_a = '0;
  assign alu_b = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural fixed-shift ALU; expectations follow SHIFT_SEQ_STEP8_EN.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] value;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [5:0]  alu_ctrl;

  int checks = 0;
  int failures = 0;
  int codes[$];
  int busy_cnt;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt), .value(value),
    .busy(busy), .done(done), .result(result), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
  );

  always_comb begin
    alu_r = 32'h0;
    case (alu_ctrl)
      6'h0A: alu_r = alu_b << 1;
      6'h0B: alu_r = alu_b << 2;
      6'h0C: alu_r = alu_b << 8;
      6'h0D: alu_r = alu_b >> 1;
      6'h0E: alu_r = alu_b >> 2;
      6'h0F: alu_r = alu_b >> 8;
      6'h10: alu_r = $unsigned($signed(alu_b) >>> 1);
      6'h11: alu_r = $unsigned($signed(alu_b) >>> 2);
      6'h12: alu_r = $unsigned($signed(alu_b) >>> 8);
      default: alu_r = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it to done; done_cyc is -1 if it never arrives.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v,
                        output int done_cyc);
    codes.delete();
    done_cyc = -1;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; value = v;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'b11; shamt = 5'd7; value = 32'h5A5A_5A5A;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (alu_ctrl != 6'h00) codes.push_back(int'(alu_ctrl));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int exp_codes[$];
    int done_at[$];
    int n_big;

    rst = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; value = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    rst = 1'b0;

    // SLL 1 by 31
    run_op(2'b00, 5'd31, 32'h0000_0001, dc);
`ifdef SHIFT_SEQ_STEP8_EN
    exp_codes = '{12, 12, 12, 11, 11, 11, 10};
`else
    exp_codes.delete();
    for (int i = 0; i < 15; i++) exp_codes.push_back(11);
    exp_codes.push_back(10);
`endif
    check("sll31_done_cycle", 32'(dc), 32'(exp_codes.size() + 1));
    check("sll31_result", result, 32'h8000_0000);
    check("sll31_ncodes", 32'(codes.size()), 32'(exp_codes.size()));
    for (int i = 0; i < exp_codes.size() && i < codes.size(); i++)
      check($sformatf("sll31_code%0d", i), 32'(codes[i]), 32'(exp_codes[i]));
    repeat (2) @(negedge clk);
    check("sll31_result_hold", result, 32'h8000_0000);
    check("alu_a_zero", alu_a, 32'h0);

    // SRA 0x8000_0000 by 13
    run_op(2'b10, 5'd13, 32'h8000_0000, dc);
`ifdef SHIFT_SEQ_STEP8_EN
    exp_codes = '{18, 17, 17, 16};
`else
    exp_codes = '{17, 17, 17, 17, 17, 17, 16};
`endif
    check("sra13_done_cycle", 32'(dc), 32'(exp_codes.size() + 1));
    check("sra13_result", result, 32'hFFFC_0000);
    check("sra13_ncodes", 32'(codes.size()), 32'(exp_codes.size()));
    for (int i = 0; i < exp_codes.size() && i < codes.size(); i++)
      check($sformatf("sra13_code%0d", i), 32'(codes[i]), 32'(exp_codes[i]));

    // SRL by 0
    run_op(2'b01, 5'd0, 32'hDEAD_BEEF, dc);
    check("srl0_done_cycle", 32'(dc), 32'd1);
    check("srl0_result", result, 32'hDEAD_BEEF);
    check("srl0_busy_cycles", 32'(busy_cnt), 32'd1);
    check("srl0_ncodes", 32'(codes.size()), 32'd0);
    @(negedge clk);
    check("srl0_busy_after", 32'(busy), 32'd0);
    check("srl0_done_after", 32'(done), 32'd0);

    // start held high, SLL 1 by 4: accepted at edges 0, 4, 8
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd4; value = 32'h0000_0001;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(c);
        check($sformatf("held_result_c%0d", c), result, 32'h0000_0010);
      end
    end
    start = 1'b0;
    check("held_ndone", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      check("held_done0", 32'(done_at[0]), 32'd3);
      check("held_done1", 32'(done_at[1]), 32'd7);
      check("held_done2", 32'(done_at[2]), 32'd11);
    end
    repeat (4) @(negedge clk);

    // reset during step 2 of SLL by 20
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd20; value = 32'h0000_0001;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_result", result, 32'h0);
    check("rstmid_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("rstmid_alu_b", alu_b, 32'h0);
    rst = 1'b0;
    dc = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("rstmid_no_done", 32'(dc), 32'd0);
    run_op(2'b00, 5'd20, 32'h0000_0003, dc);
`ifdef SHIFT_SEQ_STEP8_EN
    check("fresh_done_cycle", 32'(dc), 32'd5);
`else
    check("fresh_done_cycle", 32'(dc), 32'd11);
`endif
    check("fresh_result", result, 32'h0030_0000);

    // SRL 0xFFFF_FFFF by 31
    run_op(2'b01, 5'd31, 32'hFFFF_FFFF, dc);
    n_big = 0;
    foreach (codes[i]) if (codes[i] == 12 || codes[i] == 15 || codes[i] == 18) n_big++;
    check("srl31_result", result, 32'h0000_0001);
`ifdef SHIFT_SEQ_STEP8_EN
    check("srl31_done_cycle", 32'(dc), 32'd8);
    check("srl31_big_codes", 32'(n_big), 32'd3);
`else
    check("srl31_done_cycle", 32'(dc), 32'd17);
    check("srl31_big_codes", 32'(n_big), 32'd0);
`endif

    // reserved op executes as SLL
    run_op(2'b11, 5'd3, 32'h0000_0005, dc);
    check("rsv_result", result, 32'h0000_0028);
    check("rsv_done_cycle", 32'(dc), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
